// File: rtl/vga_dac_palette.sv
// vga_dac_palette: VGA DAC palette stage.
//   - 256x18 palette RAM; the pixel port and the CPU port work concurrently.
//   - CPU DAC registers: 3C6 (mask), 3C7 (read index/state), 3C8 (write index), 3C9 (data).
//   - Pixel index to rgb takes two clocks, one pixel per clock, with no stalls.
// Optional build macro: VGA_DAC_DEFAULT_PAL_EN
//   - When defined, entries 0-15 are loaded with the 16 CGA colours after each reset.
module vga_dac_palette #(
    parameter int          PIPE_LAT   = 2,
    parameter logic [7:0]  MASK_RESET = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  io_addr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [7:0]  io_din,
    output logic [7:0]  io_dout,
    input  logic [7:0]  pix_index,
    input  logic        pix_blank,
    output logic [17:0] rgb
);

    // The pipeline is built for a latency of exactly two clocks.
    generate
        if (PIPE_LAT != 2) begin : g_bad_pipe_lat
            $error("vga_dac_palette: PIPE_LAT must be 2");
        end
    endgenerate

    localparam logic [1:0] ADDR_MASK = 2'd0;  // 3C6
    localparam logic [1:0] ADDR_RIDX = 2'd1;  // 3C7
    localparam logic [1:0] ADDR_WIDX = 2'd2;  // 3C8
    localparam logic [1:0] ADDR_DATA = 2'd3;  // 3C9

    localparam logic [1:0] COMP_R = 2'd0;
    localparam logic [1:0] COMP_G = 2'd1;
    localparam logic [1:0] COMP_B = 2'd2;

    typedef enum logic {
        MODE_WR = 1'b0,
        MODE_RD = 1'b1
    } dac_mode_t;

    // Palette storage and CPU-visible DAC state
    logic [17:0] r_ram [0:255];
    logic [7:0]  r_mask;
    logic [7:0]  r_wr_idx;
    logic [7:0]  r_rd_idx;
    logic [1:0]  r_comp;
    dac_mode_t   r_mode;
    logic [5:0]  r_hold_r;
    logic [5:0]  r_hold_g;
    logic [7:0]  r_dout;

    // Pixel pipeline
    logic [17:0] r_pix_q;
    logic        r_blank_d1;
    logic [17:0] r_rgb;

    logic [7:0]  w_pix_addr;
    logic        w_init_busy;
    logic        w_data_wr;
    logic        w_commit;
    logic        w_data_rd;
    logic [17:0] w_rd_entry;
    logic [5:0]  w_rd_comp;
    logic [17:0] w_commit_rgb;

    assign w_pix_addr   = pix_index & r_mask;
    // A simultaneous read and write is treated as a write only.
    assign w_data_wr    = io_wr && (io_addr == ADDR_DATA) && (r_mode == MODE_WR) && !w_init_busy;
    assign w_commit     = w_data_wr && (r_comp == COMP_B);
    assign w_data_rd    = io_rd && !io_wr && (io_addr == ADDR_DATA) && (r_mode == MODE_RD);
    assign w_commit_rgb = {r_hold_r, r_hold_g, io_din[5:0]};
    assign w_rd_entry   = r_ram[r_rd_idx];

    // Select the gun the read sequencer is currently pointing at
    always_comb begin
        w_rd_comp = 6'd0;
        case (r_comp)
            COMP_R:  w_rd_comp = w_rd_entry[17:12];
            COMP_G:  w_rd_comp = w_rd_entry[11:6];
            default: w_rd_comp = w_rd_entry[5:0];
        endcase
    end

`ifdef VGA_DAC_DEFAULT_PAL_EN
    typedef enum logic [1:0] {
        INIT_IDLE = 2'd0,
        INIT_FILL = 2'd1,
        INIT_DONE = 2'd2
    } init_state_t;

    init_state_t r_init_state;
    logic [3:0]  r_init_idx;
    logic        r_init_busy;
    logic        w_fill_we;
    logic [17:0] w_fill_rgb;

    // Standard 16-colour CGA set at 6-bit DAC levels 0/21/42/63
    function automatic logic [17:0] cga_colour(input logic [3:0] idx);
        logic [17:0] c;
        case (idx)
            4'd0:    c = {6'd0,  6'd0,  6'd0 };
            4'd1:    c = {6'd0,  6'd0,  6'd42};
            4'd2:    c = {6'd0,  6'd42, 6'd0 };
            4'd3:    c = {6'd0,  6'd42, 6'd42};
            4'd4:    c = {6'd42, 6'd0,  6'd0 };
            4'd5:    c = {6'd42, 6'd0,  6'd42};
            4'd6:    c = {6'd42, 6'd21, 6'd0 };
            4'd7:    c = {6'd42, 6'd42, 6'd42};
            4'd8:    c = {6'd21, 6'd21, 6'd21};
            4'd9:    c = {6'd21, 6'd21, 6'd63};
            4'd10:   c = {6'd21, 6'd63, 6'd21};
            4'd11:   c = {6'd21, 6'd63, 6'd63};
            4'd12:   c = {6'd63, 6'd21, 6'd21};
            4'd13:   c = {6'd63, 6'd21, 6'd63};
            4'd14:   c = {6'd63, 6'd63, 6'd21};
            default: c = {6'd63, 6'd63, 6'd63};
        endcase
        return c;
    endfunction

    assign w_fill_we   = (r_init_state == INIT_FILL);
    assign w_fill_rgb  = cga_colour(r_init_idx);
    assign w_init_busy = r_init_busy;

    // Init sequencer: one idle cycle after reset, then one entry per clock for 16 clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init_state <= INIT_IDLE;
            r_init_idx   <= 4'd0;
            r_init_busy  <= 1'b1;
        end else begin
            case (r_init_state)
                INIT_IDLE: r_init_state <= INIT_FILL;
                INIT_FILL: begin
                    r_init_idx <= r_init_idx + 4'd1;
                    if (r_init_idx == 4'd15) begin
                        r_init_state <= INIT_DONE;
                        r_init_busy  <= 1'b0;
                    end
                end
                default: r_init_state <= INIT_DONE;
            endcase
        end
    end

    // Palette RAM: CPU commit or default fill on the write port, pixel read returns pre-write data
    always_ff @(posedge clk) begin
        if (w_commit)
            r_ram[r_wr_idx] <= w_commit_rgb;
        else if (w_fill_we)
            r_ram[{4'h0, r_init_idx}] <= w_fill_rgb;
        r_pix_q <= r_ram[w_pix_addr];
    end
`else
    assign w_init_busy = 1'b0;

    // Palette RAM: CPU commit on the write port, pixel read returns pre-write data
    always_ff @(posedge clk) begin
        if (w_commit)
            r_ram[r_wr_idx] <= w_commit_rgb;
        r_pix_q <= r_ram[w_pix_addr];
    end
`endif

    // Pixel pipeline: blank delayed alongside the RAM read, then the output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank_d1 <= 1'b1;
            r_rgb      <= 18'd0;
        end else begin
            r_blank_d1 <= pix_blank;
            r_rgb      <= r_blank_d1 ? 18'd0 : r_pix_q;
        end
    end

    // DAC register file: mask, indices, triplet sequencer and R/G holding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask   <= MASK_RESET;
            r_wr_idx <= 8'd0;
            r_rd_idx <= 8'd0;
            r_comp   <= COMP_R;
            r_mode   <= MODE_WR;
            r_hold_r <= 6'd0;
            r_hold_g <= 6'd0;
        end else if (io_wr) begin
            case (io_addr)
                ADDR_MASK: r_mask <= io_din;
                ADDR_RIDX: begin
                    r_rd_idx <= io_din;
                    r_comp   <= COMP_R;
                    r_mode   <= MODE_RD;
                end
                ADDR_WIDX: begin
                    r_wr_idx <= io_din;
                    r_comp   <= COMP_R;
                    r_mode   <= MODE_WR;
                end
                default: begin
                    if (w_data_wr) begin
                        case (r_comp)
                            COMP_R: begin
                                r_hold_r <= io_din[5:0];
                                r_comp   <= COMP_G;
                            end
                            COMP_G: begin
                                r_hold_g <= io_din[5:0];
                                r_comp   <= COMP_B;
                            end
                            default: begin
                                r_wr_idx <= r_wr_idx + 8'd1;
                                r_comp   <= COMP_R;
                            end
                        endcase
                    end
                end
            endcase
        end else if (w_data_rd) begin
            if (r_comp == COMP_B) begin
                r_rd_idx <= r_rd_idx + 8'd1;
                r_comp   <= COMP_R;
            end else begin
                r_comp <= r_comp + 2'd1;
            end
        end
    end

    // CPU read data register; holds until the next read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= 8'd0;
        end else if (io_rd) begin
            if (io_wr) begin
                r_dout <= 8'd0;
            end else begin
                case (io_addr)
                    ADDR_MASK: r_dout <= r_mask;
                    ADDR_RIDX: r_dout <= (r_mode == MODE_RD) ? 8'h03 : 8'h00;
                    ADDR_WIDX: r_dout <= r_wr_idx;
                    default:   r_dout <= (r_mode == MODE_RD) ? {2'b00, w_rd_comp} : 8'h00;
                endcase
            end
        end
    end

    assign io_dout = r_dout;
    assign rgb     = r_rgb;

endmodule

// File: doc/vga_dac_palette.md
Name: vga_dac_palette

Overview:
VGA DAC palette stage, directly upstream of the 18-bit-to-IRGB CGA port converter. Converts the 8-bit pixel index from the video sequencer into 18-bit analog-equivalent RGB (6 bits per gun, R in [17:12], G in [11:6], B in [5:0]). Provides the CPU-visible DAC registers at 3C6h–3C9h, with triplet sequencing and index auto-increment. The 256×18 palette RAM is dual-ported: CPU side and pixel side operate concurrently.

Parameters:
PIPE_LAT, 2, pixel index to rgb latency in clk cycles; fixed, the only legal value is 2.
MASK_RESET, 8'hFF, reset value of the pixel mask register at 3C6h.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
io_addr  input  2  register select: 0=3C6 mask, 1=3C7 read index/state, 2=3C8 write index, 3=3C9 data.
io_wr  input  1  one-cycle CPU write strobe.
io_rd  input  1  one-cycle CPU read strobe.
io_din  input  8  CPU write data.
io_dout  output  8  CPU read data, registered.
pix_index  input  8  palette index from the sequencer.
pix_blank  input  1  blanking; forces black.
rgb  output  18  palette colour to the CGA port stage.

Behaviour:
- Reset state (asynchronous) and values:
  - rgb=0, io_dout=0, pipeline blank flags=1.
  - mask=MASK_RESET, write index=0, read index=0.
  - component counter=0 (R), DAC state=write mode.
  - R/G holding registers=0.
- Pixel path, cycle n:
  - addr = pix_index & mask; the palette RAM is read synchronously.
  - Cycle n+1: RAM data and the delayed blank flag are registered.
  - Cycle n+2: rgb = blank_d2 ? 0 : ram_q.
  - Exactly 2 cycles of latency. Throughput is one pixel per clk with no stalls.
- CPU writes:
  - 3C6: mask=io_din.
  - 3C7: read index=io_din, component counter=0, state=read mode.
  - 3C8: write index=io_din, component counter=0, state=write mode.
  - 3C9 in write mode:
    - The counter steps R→G→B. R and G are held in holding registers from io_din[5:0]; io_din[7:6] are ignored.
    - On B, the full {R,G,B} triplet is committed to RAM[write index] in a single cycle.
    - After the commit, the write index increments (255 wraps to 0) and the counter returns to R.
  - 3C9 while in read mode: ignored; the counter is unchanged.
  - A partial triplet abandoned by a 3C7 or 3C8 write is discarded. The RAM is never partially updated.
- CPU reads (io_dout is valid the cycle after io_rd and holds until the next io_rd):
  - 3C6: returns the mask.
  - 3C7: returns 8'h03 in read mode, 8'h00 in write mode.
  - 3C8: returns the write index.
  - 3C9 in read mode:
    - Returns {2'b00, component} of RAM[read index], stepping R→G→B.
    - After B, the read index increments (wrapping) and the counter returns to R.
  - 3C9 in write mode: returns 8'h00; the counter is unchanged.
- Hazards:
  - A CPU commit and a pixel read to the same address in the same cycle: the pixel port returns the old value; the new value is visible from the next cycle.
  - io_rd and io_wr asserted together: the write is performed; the read returns 8'h00.
- Reset asserted mid-triplet or mid-pipeline: the state above is restored immediately. RAM contents are untouched (except as described under Optional Feature).

Optional Feature:
VGA_DAC_DEFAULT_PAL_EN

Defined:
- After reset deasserts, an init FSM (IDLE→FILL→DONE) writes the 16 standard CGA colours into entries 0–15, one per cycle, taking 16 cycles.
- The 16 colours use levels 0/21/42/63; entry 6 is brown {42,21,0}.
- init_busy is internal. While it is set, CPU writes to 3C9 are dropped and 3C6/3C7/3C8 writes still take effect.
- Pixel reads during FILL return whatever the entry held before.

Undefined:
- No FSM. The RAM powers up zero in simulation and undefined in hardware; software must program it.

Test Plan:
1. Write 3C8=05, then 3C9=2A,15,00, then pix_index=05 with blank=0 → rgb=18'b101010_010101_000000 exactly 2 cycles later; the write index reads back 06.
2. Write 3C8=FF, then two triplets (3F,3F,3F) and (01,02,03) → RAM[FF]=all-63, RAM[00]={1,2,3}; confirms the 255→0 wrap.
3. Write 3C7=05, then read 3C9 three times → io_dout=2A,15,00; 3C7 reads 03; read index=06.
4. Write 3C6=0F, pix_index=F5 → rgb=RAM[05]. Hold pix_blank=1 → rgb=0 for exactly the corresponding cycles.
5. Write 3C8=10, 3C9=3F,3F, then 3C8=11 → RAM[10] is unchanged and the counter restarts at R. Same-cycle commit to address 20 while pix_index=20 → old value first, new value the next pixel.
6. Assert reset during a triplet → rgb=0, mask=FF, state=write mode. With VGA_DAC_DEFAULT_PAL_EN defined: 16 cycles after release, pix_index=0E gives {63,63,21}.
